// File: rtl/csr_exec_if.sv
// Request, CSR-file and response signal bundle for csr_exec_unit.
// slave: the execute unit's view. master: the upstream issue logic plus the CSR file.
interface csr_exec_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CSR_AW = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [CSR_AW-1:0] req_csr;
  logic [XLEN-1:0]   req_rs1_val;
  logic [4:0]        req_rs1_idx;
  logic [4:0]        req_rd;

  logic [CSR_AW-1:0] csr_addr;
  logic [XLEN-1:0]   csr_wdata;
  logic              csr_we;
  logic [XLEN-1:0]   csr_rdata;
  logic              csr_valid;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [4:0]        rsp_rd;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_we;
  logic              rsp_illegal;

  modport slave (
    input  req_valid, req_funct3, req_csr, req_rs1_val, req_rs1_idx, req_rd,
    input  csr_rdata, csr_valid, rsp_ready,
    output req_ready, csr_addr, csr_wdata, csr_we,
    output rsp_valid, rsp_rd, rsp_data, rsp_we, rsp_illegal
  );

  modport master (
    output req_valid, req_funct3, req_csr, req_rs1_val, req_rs1_idx, req_rd,
    output csr_rdata, csr_valid, rsp_ready,
    input  req_ready, csr_addr, csr_wdata, csr_we,
    input  rsp_valid, rsp_rd, rsp_data, rsp_we, rsp_illegal
  );
endinterface

// File: rtl/csr_exec_unit.sv
// Zicsr execute stage: read CSR, compute RW/RS/RC value, single write strobe, rd writeback.
// Define CSR_EXEC_FAST_EN to merge READ and WRITE into one RDWR cycle.
module csr_exec_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CSR_AW = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  csr_exec_if.slave   bus
);

  localparam int unsigned IDXW = 5;
  localparam int unsigned OPW  = 2;
  localparam logic [OPW-1:0] OP_RW = 2'b01;
  localparam logic [OPW-1:0] OP_RS = 2'b10;
  localparam logic [OPW-1:0] OP_RC = 2'b11;

`ifdef CSR_EXEC_FAST_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RDWR = 2'd1, S_RESP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2, S_RESP = 2'd3} state_t;
`endif

  state_t            state_q, state_d;
  logic [OPW-1:0]    op_q;
  logic [CSR_AW-1:0] addr_q;
  logic [XLEN-1:0]   src_q;
  logic [XLEN-1:0]   old_q;
  logic              rs1_nz_q;
  logic [IDXW-1:0]   rd_q;
  logic              impl_q;

  logic              accept_c;
  logic              sample_c;
  logic              cur_impl_c;
  logic [XLEN-1:0]   cur_old_c;
  logic              write_int_c;
  logic              illegal_c;
  logic [XLEN-1:0]   wdata_c;

  assign accept_c = bus.req_valid && (state_q == S_IDLE);

  // In fast mode the merged cycle decides from the live CSR read; otherwise from captured values.
`ifdef CSR_EXEC_FAST_EN
  assign sample_c   = (state_q == S_RDWR);
  assign cur_old_c  = sample_c ? bus.csr_rdata : old_q;
  assign cur_impl_c = sample_c ? bus.csr_valid : impl_q;
`else
  assign sample_c   = (state_q == S_READ);
  assign cur_old_c  = old_q;
  assign cur_impl_c = impl_q;
`endif

  // Set/clear forms with a zero source register/zimm are pure reads.
  assign write_int_c = (op_q == OP_RW) || rs1_nz_q;
  assign illegal_c   = (op_q == 2'b00) || !cur_impl_c ||
                       (write_int_c && (addr_q[CSR_AW-1 -: 2] == 2'b11));

  always_comb begin
    wdata_c = '0;
    case (op_q)
      OP_RW:   wdata_c = src_q;
      OP_RS:   wdata_c = cur_old_c | src_q;
      OP_RC:   wdata_c = cur_old_c & ~src_q;
      default: wdata_c = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
`ifdef CSR_EXEC_FAST_EN
        if (bus.req_valid) state_d = S_RDWR;
`else
        if (bus.req_valid) state_d = S_READ;
`endif
      end
`ifdef CSR_EXEC_FAST_EN
      S_RDWR:  state_d = S_RESP;
`else
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = S_RESP;
`endif
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch and CSR read capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      addr_q   <= '0;
      src_q    <= '0;
      rs1_nz_q <= 1'b0;
      rd_q     <= '0;
      old_q    <= '0;
      impl_q   <= 1'b0;
    end else begin
      if (accept_c) begin
        op_q     <= bus.req_funct3[1:0];
        addr_q   <= bus.req_csr;
        src_q    <= bus.req_funct3[2] ? XLEN'(bus.req_rs1_idx) : bus.req_rs1_val;
        rs1_nz_q <= (bus.req_rs1_idx != '0);
        rd_q     <= bus.req_rd;
      end
      if (sample_c) begin
        old_q  <= bus.csr_rdata;
        impl_q <= bus.csr_valid;
      end
    end
  end

  // Outputs decoded from state and latched request
  always_comb begin
    bus.req_ready   = 1'b0;
    bus.csr_addr    = '0;
    bus.csr_wdata   = '0;
    bus.csr_we      = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_rd      = '0;
    bus.rsp_data    = '0;
    bus.rsp_we      = 1'b0;
    bus.rsp_illegal = 1'b0;
    case (state_q)
      S_IDLE: bus.req_ready = 1'b1;
`ifdef CSR_EXEC_FAST_EN
      S_RDWR: begin
        bus.csr_addr  = addr_q;
        bus.csr_wdata = wdata_c;
        bus.csr_we    = write_int_c && !illegal_c;
      end
`else
      S_READ: bus.csr_addr = addr_q;
      S_WRITE: begin
        bus.csr_addr  = addr_q;
        bus.csr_wdata = wdata_c;
        bus.csr_we    = write_int_c && !illegal_c;
      end
`endif
      S_RESP: begin
        bus.rsp_valid   = 1'b1;
        bus.rsp_rd      = rd_q;
        bus.rsp_data    = illegal_c ? '0 : old_q;
        bus.rsp_we      = (rd_q != '0) && !illegal_c;
        bus.rsp_illegal = illegal_c;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Scoreboard bench for csr_exec_unit: directed Zicsr vectors against a small stub CSR file.
module tb_csr_exec_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 12;
`ifdef CSR_EXEC_FAST_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 3;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        ill;
    int          acc;
  } rsp_exp_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic init_n;
  int   cyc;
  int   checks = 0;
  int   errors = 0;
  logic seen;

  logic [31:0] reg_800;
  logic [31:0] reg_340;

  rsp_exp_t rsp_q[$];
  wr_exp_t  wr_q[$];
  rsp_exp_t e;
  wr_exp_t  w;

  always #5 clk = ~clk;

  csr_exec_if #(.XLEN(XLEN), .CSR_AW(AW)) bus ();

  csr_exec_unit #(.XLEN(XLEN), .CSR_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stub CSR file: C00/C01 read-only, 800/340 read-write, others unimplemented
  always_comb begin
    bus.csr_rdata = '0;
    bus.csr_valid = 1'b0;
    case (bus.csr_addr)
      12'hC00: begin bus.csr_rdata = 32'h0000_0064; bus.csr_valid = 1'b1; end
      12'hC01: begin bus.csr_rdata = 32'h0000_1234; bus.csr_valid = 1'b1; end
      12'h800: begin bus.csr_rdata = reg_800;       bus.csr_valid = 1'b1; end
      12'h340: begin bus.csr_rdata = reg_340;       bus.csr_valid = 1'b1; end
      default: ;
    endcase
  end

  always @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      reg_800 <= 32'h0000_00F0;
      reg_340 <= 32'h0000_0011;
      cyc     <= 0;
    end else begin
      cyc <= cyc + 1;
      if (bus.csr_we && bus.csr_addr == 12'h800) reg_800 <= bus.csr_wdata;
      if (bus.csr_we && bus.csr_addr == 12'h340) reg_340 <= bus.csr_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected writes on csr_we and expected responses on handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (bus.csr_we) begin
        if (wr_q.size() == 0) begin
          check("csr_we_spurious", 32'(bus.csr_we), 32'd0);
        end else begin
          w = wr_q.pop_front();
          check("csr_addr", 32'(bus.csr_addr), 32'(w.addr));
          check("csr_wdata", bus.csr_wdata, w.data);
        end
      end
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_valid_spurious", 32'(bus.rsp_valid), 32'd0);
        end else begin
          e = rsp_q[0];
          if (!seen) begin
            check("rsp_latency", 32'(cyc), 32'(e.acc + int'(LAT)));
            seen = 1'b1;
          end
          if (bus.rsp_ready) begin
            void'(rsp_q.pop_front());
            check("rsp_rd", 32'(bus.rsp_rd), 32'(e.rd));
            check("rsp_data", bus.rsp_data, e.data);
            check("rsp_we", 32'(bus.rsp_we), 32'(e.we));
            check("rsp_illegal", 32'(bus.rsp_illegal), 32'(e.ill));
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [11:0] csr, input logic [31:0] rs1v,
                       input logic [4:0] idx, input logic [4:0] rd,
                       input logic [31:0] edata, input logic ewe, input logic eill,
                       input logic ewr, input logic [31:0] ewdata, input logic push);
    int n;
    @(negedge clk);
    bus.req_funct3  = f3;
    bus.req_csr     = csr;
    bus.req_rs1_val = rs1v;
    bus.req_rs1_idx = idx;
    bus.req_rd      = rd;
    bus.req_valid   = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 32'd1);
    if (push) begin
      rsp_q.push_back('{rd, edata, ewe, eill, cyc});
      if (ewr) wr_q.push_back('{csr, ewdata});
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_rsp_q", 32'(rsp_q.size()), 32'd0);
    check("drain_wr_q", 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    init_n          = 1'b0;
    rst_n           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_funct3  = '0;
    bus.req_csr     = '0;
    bus.req_rs1_val = '0;
    bus.req_rs1_idx = '0;
    bus.req_rd      = '0;
    bus.rsp_ready   = 1'b1;
    #12 init_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_csr_we", 32'(bus.csr_we), 32'd0);
    check("rst_csr_addr", 32'(bus.csr_addr), 32'd0);
    check("rst_csr_wdata", bus.csr_wdata, 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    //    f3      csr      rs1_val        idx    rd     exp_data       we    ill   wr    exp_wdata      push
    issue(3'b010, 12'hC00, 32'h0,         5'd0,  5'd5,  32'h0000_0064, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1);
    issue(3'b001, 12'hC01, 32'h0000_DEAD, 5'd3,  5'd1,  32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1);
    issue(3'b010, 12'h300, 32'h0,         5'd0,  5'd2,  32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1);
    issue(3'b100, 12'h800, 32'h0,         5'd0,  5'd3,  32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1);
    issue(3'b111, 12'h800, 32'h0,         5'h10, 5'd4,  32'h0000_00F0, 1'b1, 1'b0, 1'b1, 32'h0000_00E0, 1'b1);
    issue(3'b001, 12'h340, 32'hA5A5_0001, 5'd9,  5'd0,  32'h0000_0011, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1);
    issue(3'b010, 12'h340, 32'h0000_0F00, 5'd7,  5'd6,  32'hA5A5_0001, 1'b1, 1'b0, 1'b1, 32'hA5A5_0F01, 1'b1);
    issue(3'b011, 12'h340, 32'hFFFF_0000, 5'd8,  5'd7,  32'hA5A5_0F01, 1'b1, 1'b0, 1'b1, 32'h0000_0F01, 1'b1);
    issue(3'b110, 12'h800, 32'h0,         5'd3,  5'd9,  32'h0000_00E0, 1'b1, 1'b0, 1'b1, 32'h0000_00E3, 1'b1);
    issue(3'b101, 12'hC00, 32'h0,         5'd0,  5'd10, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1);
    issue(3'b011, 12'hC00, 32'hFFFF_FFFF, 5'd0,  5'd14, 32'h0000_0064, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1);
    drain();

    // Response backpressure: outputs hold, new requests are refused
    bus.rsp_ready = 1'b0;
    issue(3'b010, 12'h800, 32'h0, 5'd0, 5'd11, 32'h0000_00E3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.req_funct3  = 3'b001;
    bus.req_csr     = 12'h340;
    bus.req_rs1_val = 32'h1234_5678;
    bus.req_rs1_idx = 5'd1;
    bus.req_rd      = 5'd15;
    bus.req_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_rsp_data", bus.rsp_data, 32'h0000_00E3);
      check("stall_rsp_rd", 32'(bus.rsp_rd), 32'd11);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drain();

    // Reset during the write cycle aborts the instruction
    issue(3'b001, 12'h800, 32'h0000_0055, 5'd1, 5'd13, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (LAT - 2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_csr_we", 32'(bus.csr_we), 32'd0);
    check("abort_csr_addr", 32'(bus.csr_addr), 32'd0);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    end
    issue(3'b010, 12'h800, 32'h0, 5'd0, 5'd12, 32'h0000_00E3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
